store_size_unit: RTL
====================

Name: store_size_unit

Overview:
Sequential store-path controller: the narrowing counterpart of the load-side sign extenders.
- Takes a 32-bit register value and a store size (word/half/byte).
- Performs a read-modify-write against the word-addressed data memory, so only the target byte or halfword lane changes.
- Sits between the control unit and the data memory; the control unit pulses start and waits for done.

Parameters:
- MEM_LATENCY, 1, number of cycles from the registered read address to valid mem_rdata (1..3).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- size  input  2  00 = word (SW), 01 = half (SH), 10 = byte (SB); 11 is treated as word.
- addr  input  ADDR_WIDTH  byte address of the store.
- wdata  input  32  register value to store.
- mem_rdata  input  32  memory read data.
- mem_addr  output  ADDR_WIDTH  word-aligned memory address {addr[ADDR_WIDTH-1:2],2'b00}.
- mem_wdata  output  32  merged word to write.
- mem_wr  output  1  memory write strobe, one cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  one-cycle abort pulse (only with MISALIGN_CHECK_EN).

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are registered and reset to 0; state returns to IDLE.
- Capture: size, addr and wdata are latched at the start edge; later input changes are ignored.
- start while busy: ignored, no queueing.
- Lane order: little-endian; lane k = bits [8k+7:8k], where k = addr[1:0].
  - Byte store: replace lane k with wdata[7:0].
  - Half store: replace bits [16h+15:16h] with wdata[15:0], where h = addr[1].
  - Other lanes keep mem_rdata.
- States: IDLE, READ, CAPTURE, WRITE, DONE, plus ABORT (feature only).
- Word path: IDLE -start-> WRITE -> DONE -> IDLE.
  - mem_wdata = wdata; mem_wr = 1 in WRITE; done = 1 in DONE.
  - Latency: start sampled at edge 0, write at cycle 1, done at cycle 2.
- Sub-word path: IDLE -start-> READ, which is held MEM_LATENCY cycles via a down-counter (mem_addr valid, mem_wr = 0).
  - CAPTURE: register mem_rdata, merge lanes.
  - WRITE: mem_wr = 1 with the merged mem_wdata.
  - DONE: done = 1, then IDLE.
  - With MEM_LATENCY = 1, done occurs at cycle 4.
- mem_addr is stable from the first busy cycle through WRITE.
- mem_wr is never high outside WRITE, and is high for exactly one cycle per store.
- Reset mid-operation: IDLE at the next edge; mem_wr = 0; no partial write; done is not pulsed.
- done and start in the same cycle (DONE state): start is ignored; the next start is accepted in IDLE.
- Address wrap: addr is all ones (byte 0xFFFFFFFF): mem_addr = 0xFFFFFFFC, lane 3; no overflow handling.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - A half store with addr[0] = 1, or a word store with addr[1:0] != 0, goes IDLE -> ABORT -> IDLE.
  - misaligned = 1 for one cycle in ABORT; mem_wr is never asserted; done is not asserted.
- Undefined:
  - The misaligned port is tied to 0.
  - addr[0] is ignored for half stores and addr[1:0] is ignored for word stores; the store proceeds on the aligned lane.

Decomposition:
- Shared package store_pkg:
  - SIZE_WORD = 2'b00, SIZE_HALF = 2'b01, SIZE_BYTE = 2'b10.
  - State encoding constants.
  - Shared with the future load_size_unit.
- Sub-module store_lane_merge: purely combinational. Inputs: old_word, wdata, size, offset[1:0]. Output: merged_word. Instantiated in CAPTURE.

Test Plan:
- Reset, then SW addr = 0x00000010, wdata = 0xDEADBEEF -> mem_wr at cycle 1 with mem_wdata = 0xDEADBEEF, mem_addr = 0x10; done at cycle 2; exactly one read-free transaction.
- SB addr = 0x00000022, wdata = 0x123456AB, mem_rdata = 0x11223344 -> mem_addr = 0x20, mem_wdata = 0x11AB3344, done at cycle 4 (MEM_LATENCY = 1).
- SH addr = 0x00000032, wdata = 0x0000CAFE, mem_rdata = 0xAAAABBBB -> mem_wdata = 0xCAFEBBBB; repeat with MEM_LATENCY = 3 -> done at cycle 6.
- start pulsed during busy, then reset asserted in READ -> busy = 0 next cycle, mem_wr never high, done never high; a fresh SB afterwards completes normally.
- With MISALIGN_CHECK_EN, SH addr = 0x00000041 -> misaligned pulse at cycle 1, no mem_wr, no done. Without the macro -> write to lane h = 0 with mem_wdata[15:0] = wdata[15:0].
- Back-to-back: SB then immediate SW with start held high -> the second start is accepted only after return to IDLE; two distinct single-cycle mem_wr pulses.

Source files
------------

// File: rtl/store_pkg.sv
// Shared store/load size definitions and FSM state encoding.
// Also intended for the load-side size unit.
package store_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ABORT   = 3'd5
    } store_state_t;

    // Size code 2'b11 is not a sub-word store; it behaves as a word store.
    function automatic logic is_subword(input logic [1:0] sz);
        return (sz == SIZE_HALF) || (sz == SIZE_BYTE);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge: overlays the byte or halfword
// selected by offset onto old_word; a word size replaces every lane.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged_word
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] src_byte;

            always_comb begin
                lane_hit = 1'b1;
                src_byte = wdata[8*gi +: 8];
                case (size)
                    SIZE_BYTE: begin
                        lane_hit = (offset == 2'(gi));
                        src_byte = wdata[7:0];
                    end
                    SIZE_HALF: begin
                        // offset[0] is deliberately ignored: the half lane is chosen by offset[1]
                        lane_hit = (offset[1] == 1'(gi / 2));
                        src_byte = wdata[8*(gi % 2) +: 8];
                    end
                    default: ;
                endcase
            end

            assign merged_word[8*gi +: 8] = lane_hit ? src_byte : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_size_unit.sv
// Store-path read-modify-write controller for word/half/byte stores.
// Optional macro MISALIGN_CHECK_EN aborts misaligned half/word stores.
module store_size_unit
    import store_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned
);

    localparam logic [1:0] LAT_LOAD = 2'(MEM_LATENCY - 1);

    store_state_t          state_reg, state_next;
    logic [1:0]            lat_cnt_reg, lat_cnt_next;
    logic [1:0]            size_reg;
    logic [1:0]            offset_reg;
    logic [31:0]           wdata_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]           mem_wdata_reg;
    logic [31:0]           merged_word;
    logic                  mem_wr_reg, busy_reg, done_reg;
    logic                  start_misaligned;

`ifdef MISALIGN_CHECK_EN
    logic misaligned_reg;
    assign start_misaligned = ((size == SIZE_HALF) && addr[0]) ||
                              (!is_subword(size) && (addr[1:0] != 2'b00));
    assign misaligned = misaligned_reg;
`else
    assign start_misaligned = 1'b0;
    assign misaligned       = 1'b0;
`endif

    store_lane_merge u_merge (
        .old_word    (mem_rdata),
        .wdata       (wdata_reg),
        .size        (size_reg),
        .offset      (offset_reg),
        .merged_word (merged_word)
    );

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (start_misaligned) begin
                        state_next = ST_ABORT;
                    end else if (is_subword(size)) begin
                        state_next   = ST_READ;
                        lat_cnt_next = LAT_LOAD;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (lat_cnt_reg == 2'd0) state_next = ST_CAPTURE;
                else                     lat_cnt_next = lat_cnt_reg - 2'd1;
            end
            ST_CAPTURE: state_next = ST_WRITE;
            ST_WRITE:   state_next = ST_DONE;
            // start seen in DONE or ABORT is dropped; only IDLE accepts a request
            ST_DONE:    state_next = ST_IDLE;
            ST_ABORT:   state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lat_cnt_reg   <= '0;
            size_reg      <= '0;
            offset_reg    <= '0;
            wdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wr_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            misaligned_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            mem_wr_reg  <= (state_next == ST_WRITE);
            busy_reg    <= (state_next != ST_IDLE);
            done_reg    <= (state_next == ST_DONE);
`ifdef MISALIGN_CHECK_EN
            misaligned_reg <= (state_next == ST_ABORT);
`endif
            if ((state_reg == ST_IDLE) && start) begin
                size_reg      <= size;
                offset_reg    <= addr[1:0];
                wdata_reg     <= wdata;
                mem_addr_reg  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_reg <= wdata;
            end
            if (state_reg == ST_CAPTURE) begin
                mem_wdata_reg <= merged_word;
            end
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wr    = mem_wr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
